// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and stall controller for a 5-stage MIPS pipeline. It looks at the
//   decoded control bits held in IF/ID, ID/EX and EX/MEM, and at the
//   data-memory handshake. From these it drives the per-stage pipeline
//   register write enables and the flush (bubble) controls.
//
//   It handles:
//     - load-use stalls (one bubble per dependent load),
//     - taken-branch and jump flushes,
//     - multi-cycle memory waits, with a timeout that halts the pipeline,
//     - saturating stall and flush event counters.
//
//   The pipeline controls are Mealy outputs (combinational from state and
//   inputs). The FSM state, wait counter, event counters and mem_err are
//   registered.
//
// Parameters
//   MEM_TIMEOUT  consecutive frozen cycles allowed before the fatal halt (>=2)
//   CNT_W        width of the saturating performance counters
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   ifid_op/rs/rt      opcode and source fields of the instruction in IF/ID
//   idex_memread       MemRead bit of the ID/EX M bundle
//   idex_rt            destination rt of the load in ID/EX
//   id_jump            Jump decoded in ID
//   mem_branch_taken   Branch & Zero resolved in EX/MEM
//   mem_req            EX/MEM MemRead | MemWrite
//   mem_ready          data memory completes its access this cycle
//   *_we               pipeline register write enables (PC .. MEM/WB)
//   *_flush            squash controls for IF/ID, ID/EX and EX/MEM
//   stall_cnt          saturating count of stall cycles
//   flush_cnt          saturating count of flush events
//   mem_err            sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ifid_op,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             id_jump,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state_r;
    logic [WCNT_W-1:0]  wcnt_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               mem_err_r;

    logic               rs_used_s;
    logic               rt_used_s;
    logic               load_use_s;
    logic               freeze_s;
    logic               halted_s;
    logic               stall_ev_s;
    logic               flush_ev_s;

    // Every opcode except J reads rs.
    function automatic logic rs_is_source(input logic [5:0] op);
        logic used;
        case (op)
            OP_J:    used = 1'b0;
            default: used = 1'b1;
        endcase
        return used;
    endfunction

    // Only R-type, sw and beq read rt; for other I-types rt is a destination.
    function automatic logic rt_is_source(input logic [5:0] op);
        logic used;
        case (op)
            OP_RTYPE: used = 1'b1;
            OP_SW:    used = 1'b1;
            OP_BEQ:   used = 1'b1;
            default:  used = 1'b0;
        endcase
        return used;
    endfunction

    // Hazard detection: operand decode, load-use match and memory freeze.
    always_comb begin
        rs_used_s  = rs_is_source(ifid_op);
        rt_used_s  = rt_is_source(ifid_op);
        // $0 is hard-wired, so a load targeting it can never feed a consumer.
        load_use_s = idex_memread && (idex_rt != 5'd0) &&
                     ((rs_used_s && (ifid_rs == idex_rt)) ||
                      (rt_used_s && (ifid_rt == idex_rt)));
        freeze_s   = mem_req && !mem_ready;
        // Any encoding other than RUN/WAIT is treated as a halt so that a
        // corrupted state register freezes the pipeline instead of running on.
        halted_s   = (state_r != ST_RUN) && (state_r != ST_WAIT);
    end

    // Prioritised pipeline control; the first matching condition wins.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        stall_ev_s  = 1'b0;
        flush_ev_s  = 1'b0;
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (halted_s) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (freeze_s) begin
            // Whole pipeline holds. Branch, jump and load-use are evaluated
            // again on the first cycle after the memory completes.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_we    = 1'b0;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
            stall_ev_s = 1'b1;
        end else if (mem_branch_taken) begin
            // Squash the three wrong-path instructions in IF/ID, ID/EX and EX.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_ev_s  = 1'b1;
        end else if (id_jump) begin
            ifid_flush = 1'b1;
            flush_ev_s = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID, and inject a single bubble behind the load.
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_ev_s = 1'b1;
        end else begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            idex_we     = 1'b1;
            exmem_we    = 1'b1;
            memwb_we    = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
        end
    end

    // Memory-wait FSM with timeout. The counter holds the number of frozen
    // cycles already seen, so a freeze while it equals MEM_TIMEOUT-1 is the
    // MEM_TIMEOUT-th frozen cycle and triggers the halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            wcnt_r    <= '0;
            mem_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (freeze_s) begin
                        state_r <= ST_WAIT;
                        wcnt_r  <= WCNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (freeze_s) begin
                        if (wcnt_r == WCNT_LAST) begin
                            state_r   <= ST_HALT;
                            mem_err_r <= 1'b1;
                        end else begin
                            wcnt_r <= wcnt_r + WCNT_W'(1);
                        end
                    end else begin
                        state_r <= ST_RUN;
                        wcnt_r  <= '0;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r   <= ST_HALT;
                    mem_err_r <= 1'b1;
                end
            endcase
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (stall_ev_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_ev_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign mem_err   = mem_err_r;

endmodule
